sub_array_stream_sequencer: RTL and testbench
=============================================

Name: sub_array_stream_sequencer

Overview:
Sequential controller that accepts one full ROWS x COLS matrix as a flat row-major word and streams its elements out one per beat in sub-array order.
- Top phase: the first SUB_ROWS rows, column-major.
- Bottom phase: the remaining ROWS-SUB_ROWS rows, column-major.

The emitted order matches the sub-array flattening layout used by the array-conversion blocks. It feeds narrow downstream datapaths (serializers, PE feeders) through a valid/ready stream.

Parameters:
BIT_WIDTH, 4, bits per element
ROWS, 8, matrix rows
COLS, 8, matrix columns
SUB_ROWS, 4, rows in top sub-array; legal range 1..ROWS

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  ROWS*COLS*BIT_WIDTH  matrix; element (r,c) at bits [(r*COLS+c)*BIT_WIDTH +: BIT_WIDTH]
in_valid  input  1  matrix offered
in_ready  output  1  block can accept a matrix
out_data  output  BIT_WIDTH  current element
out_row  output  $clog2(ROWS) (min 1)  row index of out_data
out_col  output  $clog2(COLS) (min 1)  column index of out_data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts beat
out_last  output  1  final element of matrix
flush  input  1  synchronous abort; return to IDLE

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready=1; out_valid=0; out_last=0; out_data=0; out_row=0; out_col=0; buffer contents don't-care.
- States: IDLE, TOP, BOT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: register in_data into an internal buffer, set row=0, col=0, go to TOP.
  - First out_valid appears in the cycle after acceptance (latency 1).
- TOP / BOT:
  - in_ready=0, out_valid=1.
  - out_data = buffer[row][col], driven from registered indices.
  - A beat transfers on out_valid&&out_ready. Without a transfer, out_data/out_row/out_col/out_last hold stable.
- TOP advance on transfer:
  - row increments.
  - If row==SUB_ROWS-1: row resets to 0 and col increments.
  - If also col==COLS-1: row=SUB_ROWS, col=0, go to BOT. If SUB_ROWS==ROWS, go straight to IDLE instead.
- BOT advance on transfer:
  - row increments.
  - If row==ROWS-1: row=SUB_ROWS and col increments.
  - If also col==COLS-1: go to IDLE.
- out_last=1 exactly on the ROWS*COLS-th beat:
  - TOP at (SUB_ROWS-1, COLS-1) when SUB_ROWS==ROWS;
  - otherwise BOT at (ROWS-1, COLS-1).
- Back-to-back: the cycle after the last transfer is in IDLE with in_ready=1. A new matrix can be accepted that cycle, giving a 1-cycle bubble between matrices.
- Throughput: 1 element/cycle with out_ready held high. One matrix takes ROWS*COLS+1 cycles, including the acceptance cycle.
- flush:
  - Any state, next cycle: IDLE, out_valid=0, indices 0.
  - Flush has priority over a simultaneous transfer or acceptance; the accepted matrix is discarded.
- in_valid while in TOP/BOT is ignored; in_ready is low.
- Index arithmetic is unsigned with no wrap beyond the stated limits. SUB_ROWS outside 1..ROWS is a configuration error; an elaboration-time check stops the build.

Optional Feature:
Macro SUB_ARRAY_SEQ_STALL_CNT_EN.
- When defined:
  - Extra output port stall_cnt, 16 bits.
  - Counts cycles with out_valid=1 && out_ready=0; saturates at 16'hFFFF.
  - Cleared to 0 on reset, flush, and each matrix acceptance.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Ordering: BIT_WIDTH=8, defaults otherwise, element (r,c)=r*8+c, out_ready=1.
  - Beats 0..5 = 0,8,16,24,1,9; beat 31 = 31 (row 3, col 7); beat 32 = 32 (row 4, col 0); beat 63 = 63 with out_last=1.
  - in_ready returns to 1 one cycle later.
- Backpressure: out_ready low for 3 cycles at beat 10 (value 18, row 2, col 2).
  - out_data/out_row/out_col hold at 18/2/2 for all 3 cycles; no beat is lost or repeated.
  - With SUB_ARRAY_SEQ_STALL_CNT_EN defined, stall_cnt=3 at end.
- Degenerate split: SUB_ROWS=ROWS=8.
  - Pure column-major: beats 0,8,...,56,1,...
  - out_last on (7,7) value 63; BOT is never entered.
- Flush mid-stream: assert flush at beat 20.
  - Next cycle out_valid=0, in_ready=1.
  - A new matrix with all elements 0xAA then streams from (0,0) = 0xAA.
- Async reset mid-stream: pull rst_n low during beat 40 without a clock edge.
  - out_valid=0 and in_ready=1 immediately.
  - After release, idle until in_valid.
- Back-to-back: in_valid held high with two matrices.
  - Second matrix accepted in the cycle after the first's out_last.
  - Exactly 1 idle cycle (out_valid=0) between the matrices.

Source files
------------

// File: rtl/sub_array_stream_sequencer.sv
// Buffers one ROWS x COLS matrix and streams it out one element per beat in sub-array order.
// Optional build macro SUB_ARRAY_SEQ_STALL_CNT_EN adds the 16-bit stall_cnt output.
//
// state | meaning
// IDLE  | waiting for a matrix, in_ready high
// TOP   | streaming rows 0..SUB_ROWS-1, column-major
// BOT   | streaming rows SUB_ROWS..ROWS-1, column-major
module sub_array_stream_sequencer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [BIT_WIDTH-1:0]           out_data,
    output logic [RW-1:0]                  out_row,
    output logic [CW-1:0]                  out_col,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    input  logic                           flush
`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, TOP, BOT} state_t;

    localparam logic [RW-1:0] TOP_LAST  = RW'(SUB_ROWS - 1);
    localparam logic [RW-1:0] BOT_FIRST = RW'(SUB_ROWS % ROWS);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

    generate
        if (SUB_ROWS < 1 || SUB_ROWS > ROWS) begin : g_bad_sub_rows
            $error("sub_array_stream_sequencer: SUB_ROWS must be within 1..ROWS");
        end
    endgenerate

    state_t               state;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [BIT_WIDTH-1:0] mem [ROWS][COLS];
    logic                 accept;

    // All stream outputs decode straight from flops, so they hold while out_ready is low.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state != IDLE);
    assign accept    = in_ready && in_valid;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_data  = out_valid ? mem[row_q][col_q] : '0;
    // Only the final beat can sit on the bottom-right corner, whichever phase owns it.
    assign out_last  = out_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    mem[r][c] <= in_data[(r*COLS+c)*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row_q <= '0;
            col_q <= '0;
        end else if (flush) begin
            state <= IDLE;
            row_q <= '0;
            col_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= TOP;
                        row_q <= '0;
                        col_q <= '0;
                    end
                end
                TOP: begin
                    if (out_ready) begin
                        if (row_q != TOP_LAST) begin
                            row_q <= row_q + 1'b1;
                        end else if (col_q != COL_LAST) begin
                            row_q <= '0;
                            col_q <= col_q + 1'b1;
                        end else if (SUB_ROWS == ROWS) begin
                            state <= IDLE;
                            row_q <= '0;
                            col_q <= '0;
                        end else begin
                            state <= BOT;
                            row_q <= BOT_FIRST;
                            col_q <= '0;
                        end
                    end
                end
                BOT: begin
                    if (out_ready) begin
                        if (row_q != ROW_LAST) begin
                            row_q <= row_q + 1'b1;
                        end else if (col_q != COL_LAST) begin
                            row_q <= BOT_FIRST;
                            col_q <= col_q + 1'b1;
                        end else begin
                            state <= IDLE;
                            row_q <= '0;
                            col_q <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    row_q <= '0;
                    col_q <= '0;
                end
            endcase
        end
    end

`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (flush || accept) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sub_array_stream_sequencer.sv
// Directed bench for sub_array_stream_sequencer: default 4/4 split (u_dut_a) and a
// degenerate SUB_ROWS=ROWS instance (u_dut_b), both with 8-bit elements.
module tb_sub_array_stream_sequencer;

    localparam int BW = 8;
    localparam int N  = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*N*BW-1:0] in_data;
    logic           in_valid_a, in_valid_b;
    logic           out_ready;
    logic           flush;

    logic           in_ready_a, out_valid_a, out_last_a;
    logic [BW-1:0]  out_data_a;
    logic [2:0]     out_row_a, out_col_a;
    logic [15:0]    stall_a;
    logic           in_ready_b, out_valid_b, out_last_b;
    logic [BW-1:0]  out_data_b;
    logic [2:0]     out_row_b, out_col_b;
    logic [15:0]    stall_b;

    int n_checks = 0;
    int n_fail   = 0;
    int got_d [64];
    int got_r [64];
    int got_c [64];

    always #5 clk = ~clk;

    sub_array_stream_sequencer #(.BIT_WIDTH(BW), .ROWS(N), .COLS(N), .SUB_ROWS(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .out_data(out_data_a), .out_row(out_row_a), .out_col(out_col_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_last(out_last_a), .flush(flush)
`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    sub_array_stream_sequencer #(.BIT_WIDTH(BW), .ROWS(N), .COLS(N), .SUB_ROWS(N)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out_data(out_data_b), .out_row(out_row_b), .out_col(out_col_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_last(out_last_b), .flush(flush)
`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*N*BW-1:0] ramp();
        logic [N*N*BW-1:0] m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[(r*N+c)*BW +: BW] = 8'(r*N + c);
        return m;
    endfunction

    // Beat k -> (row, col): column-major over the top rows, then over the bottom rows.
    task automatic exp_pos(input int k, input int sub, output int r, output int c);
        if (k < sub*N) begin
            c = k / sub;
            r = k % sub;
        end else begin
            c = (k - sub*N) / (N - sub);
            r = sub + (k - sub*N) % (N - sub);
        end
    endtask

    task automatic stream_a(input int nbeats, input bit aa, input int stall_beat, input int stall_len);
        int er, ec, ev;
        for (int k = 0; k < nbeats; k++) begin
            exp_pos(k, 4, er, ec);
            ev = aa ? 32'hAA : er*N + ec;
            got_d[k] = int'(out_data_a);
            got_r[k] = int'(out_row_a);
            got_c[k] = int'(out_col_a);
            check($sformatf("a_valid[%0d]", k), 32'(out_valid_a), 1);
            check($sformatf("a_data[%0d]", k), 32'(out_data_a), ev);
            check($sformatf("a_row[%0d]", k), 32'(out_row_a), er);
            check($sformatf("a_col[%0d]", k), 32'(out_col_a), ec);
            check($sformatf("a_last[%0d]", k), 32'(out_last_a), (k == 63) ? 1 : 0);
            if (k == stall_beat) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    tick();
                    check($sformatf("hold_data[%0d]", s), 32'(out_data_a), ev);
                    check($sformatf("hold_row[%0d]", s), 32'(out_row_a), er);
                    check($sformatf("hold_col[%0d]", s), 32'(out_col_a), ec);
                    check($sformatf("hold_valid[%0d]", s), 32'(out_valid_a), 1);
                end
                out_ready = 1'b1;
            end
            tick();
        end
    endtask

    task automatic accept_a(input logic [N*N*BW-1:0] m);
        in_data    = m;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int tb_beat [9] = '{0, 1, 2, 3, 4, 5, 31, 32, 63};
        int tb_val  [9] = '{0, 8, 16, 24, 1, 9, 31, 32, 63};
        int tb_row  [9] = '{0, 1, 2, 3, 0, 1, 3, 4, 7};
        int tb_col  [9] = '{0, 0, 0, 0, 1, 1, 7, 0, 7};
        int er, ec;

        rst_n = 1'b0; in_data = '0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready = 1'b1; flush = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready_a), 1);
        check("rst_out_valid", 32'(out_valid_a), 0);
        check("rst_out_last", 32'(out_last_a), 0);
        check("rst_out_data", 32'(out_data_a), 0);
        check("rst_out_row", 32'(out_row_a), 0);
        check("rst_out_col", 32'(out_col_a), 0);
        #14 rst_n = 1'b1;
        tick();
        check("idle_valid", 32'(out_valid_a), 0);

        // Ordering with out_ready held high.
        accept_a(ramp());
        stream_a(64, 1'b0, -1, 0);
        check("order_in_ready_after", 32'(in_ready_a), 1);
        check("order_valid_after", 32'(out_valid_a), 0);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("order_tbl_val[%0d]", tb_beat[i]), got_d[tb_beat[i]], tb_val[i]);
            check($sformatf("order_tbl_row[%0d]", tb_beat[i]), got_r[tb_beat[i]], tb_row[i]);
            check($sformatf("order_tbl_col[%0d]", tb_beat[i]), got_c[tb_beat[i]], tb_col[i]);
        end

        // Backpressure: three stall cycles at beat 10.
        accept_a(ramp());
        stream_a(64, 1'b0, 10, 3);
        check("bp_b10_val", got_d[10], 18);
        check("bp_b10_row", got_r[10], 2);
        check("bp_b10_col", got_c[10], 2);
        check("bp_b11_val", got_d[11], 26);
        check("bp_done_valid", 32'(out_valid_a), 0);
`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
        check("bp_stall_cnt", 32'(stall_a), 3);
`endif

        // Degenerate split: pure column-major, never enters BOT.
        in_data = ramp();
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        for (int k = 0; k < 64; k++) begin
            exp_pos(k, N, er, ec);
            check($sformatf("b_data[%0d]", k), 32'(out_data_b), er*N + ec);
            check($sformatf("b_row[%0d]", k), 32'(out_row_b), er);
            check($sformatf("b_last[%0d]", k), 32'(out_last_b), (k == 63) ? 1 : 0);
            if (k == 1) check("b_beat1_const", 32'(out_data_b), 8);
            if (k == 63) check("b_beat63_const", 32'(out_data_b), 63);
            tick();
        end
        check("b_done_valid", 32'(out_valid_b), 0);
        check("b_done_ready", 32'(in_ready_b), 1);

        // Flush at beat 20, then a fresh all-0xAA matrix.
        out_ready = 1'b1;
        accept_a(ramp());
        stream_a(20, 1'b0, 5, 2);
        check("fl_b20_val", 32'(out_data_a), 5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid_a), 0);
        check("fl_in_ready", 32'(in_ready_a), 1);
        check("fl_row", 32'(out_row_a), 0);
        check("fl_col", 32'(out_col_a), 0);
`ifdef SUB_ARRAY_SEQ_STALL_CNT_EN
        check("fl_stall_cnt", 32'(stall_a), 0);
`endif
        accept_a({64{8'hAA}});
        check("fl_new_first", 32'(out_data_a), 32'hAA);
        stream_a(64, 1'b1, -1, 0);

        // Asynchronous reset during beat 40, between clock edges.
        accept_a(ramp());
        stream_a(40, 1'b0, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid_a), 0);
        check("ar_in_ready", 32'(in_ready_a), 1);
        check("ar_data", 32'(out_data_a), 0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ar_idle[%0d]", i), 32'(out_valid_a), 0);
        end

        // Back-to-back with in_valid held high; second matrix is all 0xAA.
        in_data = ramp();
        in_valid_a = 1'b1;
        tick();
        in_data = {64{8'hAA}};
        stream_a(64, 1'b0, -1, 0);
        check("b2b_gap_valid", 32'(out_valid_a), 0);
        check("b2b_gap_ready", 32'(in_ready_a), 1);
        tick();
        in_valid_a = 1'b0;
        check("b2b_second_valid", 32'(out_valid_a), 1);
        check("b2b_second_data", 32'(out_data_a), 32'hAA);
        stream_a(64, 1'b1, -1, 0);
        check("b2b_end_valid", 32'(out_valid_a), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
